im_lut_prog: RTL and testbench

- Writable, parametrised immediate lookup table for the LOAD_IMM path. Replaces the fixed 32-entry ROM-style table.
- Depth, width and number of read ports are configurable.
- Entries are loaded at run time through a single-entry write port or an auto-incrementing burst (stream) loader.
- The table self-clears after reset and on request. Reads are combinational, with same-cycle write forwarding.

---
 rtl/im_lut_prog.sv | 138 +++++++++++++
 tb/tb_im_lut_prog.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_lut_prog.sv
// im_lut_prog: writable immediate lookup table for the LOAD_IMM path.
// Self-clearing, single-entry writes, burst loader, forwarded reads.
module im_lut_prog #(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int INDEX_WIDTH     = 5,
  parameter int NUM_RD_PORTS    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_RD_PORTS*INDEX_WIDTH-1:0]     rd_index,
  output logic [NUM_RD_PORTS*DATA_PATH_WIDTH-1:0] rd_value,
  input  logic                                   wr_valid,
  input  logic [INDEX_WIDTH-1:0]                  wr_index,
  input  logic [DATA_PATH_WIDTH-1:0]              wr_data,
  output logic                                   wr_ready,
  input  logic                                   stream_start,
  input  logic [INDEX_WIDTH-1:0]                  stream_base,
  input  logic [INDEX_WIDTH:0]                    stream_len,
  input  logic                                   stream_valid,
  input  logic [DATA_PATH_WIDTH-1:0]              stream_data,
  output logic                                   stream_ready,
  output logic                                   stream_done,
  input  logic                                   clear_req,
  output logic                                   lut_ready
);

  localparam int DW    = DATA_PATH_WIDTH;
  localparam int IW    = INDEX_WIDTH;
  localparam int LW    = INDEX_WIDTH + 1;
  localparam int DEPTH = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   clr_ptr;
  logic [IW-1:0]   ptr;
  logic [LW-1:0]   remaining;
  logic [DW-1:0]   mem [DEPTH];

  logic            wr_fire;
  logic            beat_fire;
  logic            mem_we;
  logic [IW-1:0]   mem_idx;
  logic [DW-1:0]   mem_dat;

  assign lut_ready    = (state != CLEAR);
  assign wr_ready     = (state == IDLE);
  assign stream_ready = (state == STREAM);

  assign wr_fire   = wr_valid && wr_ready && !clear_req;
  assign beat_fire = stream_valid && stream_ready && !clear_req;

  // Select the single table write for this cycle
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = '0;
    mem_dat = '0;
    unique case (1'b1)
      state == CLEAR: begin
        mem_we  = 1'b1;
        mem_idx = clr_ptr;
      end
      wr_fire: begin
        mem_we  = 1'b1;
        mem_idx = wr_index;
        mem_dat = wr_data;
      end
      beat_fire: begin
        mem_we  = 1'b1;
        mem_idx = ptr;
        mem_dat = stream_data;
      end
      default: ;
    endcase
  end

  // Table storage; contents are zeroed by the CLEAR sweep, not by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_dat;
  end

  // Control FSM with sweep pointer, burst pointer and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      ptr         <= '0;
      remaining   <= '0;
      stream_done <= 1'b0;
    end else begin
      stream_done <= 1'b0;
      if (clear_req) begin
        state   <= CLEAR;
        clr_ptr <= '0;
      end else begin
        unique case (state)
          CLEAR: begin
            clr_ptr <= clr_ptr + IW'(1);
            if (clr_ptr == IW'(DEPTH - 1)) state <= IDLE;
          end
          IDLE: begin
            if (stream_start && stream_len != '0) begin
              ptr       <= stream_base;
              remaining <= stream_len;
              state     <= STREAM;
            end
          end
          STREAM: begin
            if (beat_fire) begin
              ptr       <= ptr + IW'(1);
              remaining <= remaining - LW'(1);
              if (remaining == LW'(1)) begin
                state       <= IDLE;
                stream_done <= 1'b1;
              end
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

  // Combinational read ports with same-cycle forwarding
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [IW-1:0] idx;
    assign idx = rd_index[p*IW +: IW];
    assign rd_value[p*DW +: DW] =
      (state == CLEAR)          ? '0 :
      (mem_we && mem_idx == idx) ? mem_dat :
                                   mem[idx];
  end

endmodule

// File: tb/tb_im_lut_prog.sv
// tb_im_lut_prog: directed checks for im_lut_prog.
// Table vectors for IDLE writes, sequences for burst/clear/reset.
module tb_im_lut_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_index;
  logic [15:0] rd_value;
  logic        wr_valid;
  logic [4:0]  wr_index;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        stream_start;
  logic [4:0]  stream_base;
  logic [5:0]  stream_len;
  logic        stream_valid;
  logic [7:0]  stream_data;
  logic        stream_ready;
  logic        stream_done;
  logic        clear_req;
  logic        lut_ready;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  im_lut_prog dut (
    .clk(clk), .rst_n(rst_n),
    .rd_index(rd_index), .rd_value(rd_value),
    .wr_valid(wr_valid), .wr_index(wr_index),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .stream_start(stream_start),
    .stream_base(stream_base),
    .stream_len(stream_len),
    .stream_valid(stream_valid),
    .stream_data(stream_data),
    .stream_ready(stream_ready),
    .stream_done(stream_done),
    .clear_req(clear_req),
    .lut_ready(lut_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stream_done) done_cnt++;

  typedef struct {
    logic       wv;
    logic [4:0] wi;
    logic [7:0] wd;
    logic [4:0] r0;
    logic [4:0] r1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] port(input int p);
    return rd_value[p*8 +: 8];
  endfunction

  task automatic rd(input logic [4:0] a,
                    output logic [7:0] v);
    rd_index[4:0] = a;
    #1;
    v = port(0);
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (!lut_ready && n < 100) begin
      chk({nm, "_wr_ready_low"}, wr_ready, 1'b0);
      step();
      n++;
    end
    chk({nm, "_clear_cycles"}, n, 32);
    chk({nm, "_wr_ready_up"}, wr_ready, 1'b1);
  endtask

  task automatic beat(input logic [7:0] d);
    stream_valid = 1'b1;
    stream_data  = d;
    #1;
    chk("beat_wr_ready", wr_ready, 1'b0);
    chk("beat_ready", stream_ready, 1'b1);
    step();
    stream_valid = 1'b0;
  endtask

  task automatic start(input logic [4:0] b,
                       input logic [5:0] l);
    stream_start = 1'b1;
    stream_base  = b;
    stream_len   = l;
    step();
    stream_start = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int d0;

    tbl[0] = '{1'b1, 5'd3, 8'h0A, 5'd3, 5'd7, 8'h0A, 8'h00};
    tbl[1] = '{1'b1, 5'd7, 8'hF0, 5'd3, 5'd7, 8'h0A, 8'hF0};
    tbl[2] = '{1'b0, 5'd0, 8'h00, 5'd3, 5'd7, 8'h0A, 8'hF0};
    tbl[3] = '{1'b1, 5'd9, 8'h55, 5'd9, 5'd9, 8'h55, 8'h55};
    tbl[4] = '{1'b0, 5'd9, 8'hEE, 5'd9, 5'd3, 8'h55, 8'h0A};
    tbl[5] = '{1'b1, 5'd9, 8'h66, 5'd9, 5'd31, 8'h66, 8'h00};

    rst_n = 1'b0;
    rd_index = '0;
    wr_valid = 0; wr_index = '0; wr_data = '0;
    stream_start = 0; stream_base = '0;
    stream_len = '0; stream_valid = 0;
    stream_data = '0; clear_req = 0;

    // reset state
    step(); step();
    chk("rst_lut_ready", lut_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_stream_ready", stream_ready, 1'b0);
    chk("rst_stream_done", stream_done, 1'b0);
    chk("rst_rd_value", rd_value, 16'h0);
    rst_n = 1'b1;
    wait_clear("init");
    rd_index = {5'd17, 5'd4};
    #1;
    chk("init_rd_value", rd_value, 16'h0);

    // table-driven IDLE writes and forwarded reads
    for (int i = 0; i < 6; i++) begin
      wr_valid = tbl[i].wv;
      wr_index = tbl[i].wi;
      wr_data  = tbl[i].wd;
      rd_index = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("vec%0d_p0", i), port(0), tbl[i].e0);
      chk($sformatf("vec%0d_p1", i), port(1), tbl[i].e1);
      step();
    end
    wr_valid = 1'b0;

    // burst at 30 with wrap and a valid gap
    d0 = done_cnt;
    start(5'd30, 6'd4);
    beat(8'h11);
    beat(8'h22);
    step();
    chk("gap_wr_ready", wr_ready, 1'b0);
    step();
    beat(8'h33);
    stream_valid = 1'b1;
    stream_data  = 8'h44;
    rd_index[4:0] = 5'd1;
    #1;
    chk("beat4_fwd", port(0), 8'h44);
    chk("beat4_no_done", stream_done, 1'b0);
    step();
    stream_valid = 1'b0;
    chk("done_pulse", stream_done, 1'b1);
    chk("back_idle", wr_ready, 1'b1);
    step();
    chk("done_gone", stream_done, 1'b0);
    chk("done_count", done_cnt - d0, 1);
    rd(5'd30, v); chk("e30", v, 8'h11);
    rd(5'd31, v); chk("e31", v, 8'h22);
    rd(5'd0, v);  chk("e0", v, 8'h33);
    rd(5'd1, v);  chk("e1", v, 8'h44);

    // zero-length start is ignored
    d0 = done_cnt;
    start(5'd30, 6'd0);
    chk("len0_idle", wr_ready, 1'b1);
    chk("len0_no_stream", stream_ready, 1'b0);
    step();
    chk("len0_no_done", done_cnt - d0, 0);
    rd(5'd30, v); chk("len0_e30", v, 8'h11);

    // full-depth burst from base 5
    start(5'd5, 6'd32);
    for (int i = 0; i < 32; i++) begin
      stream_valid = 1'b1;
      stream_data  = 8'h80 + 8'(i);
      step();
    end
    stream_valid = 1'b0;
    chk("full_done", stream_done, 1'b1);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      chk($sformatf("full_e%0d", i), v,
          8'h80 + 8'((i + 27) % 32));
    end

    // clear_req aborts a burst and drops the beat
    d0 = done_cnt;
    start(5'd10, 6'd4);
    beat(8'hA1);
    beat(8'hA2);
    stream_valid = 1'b1;
    stream_data  = 8'hA3;
    clear_req    = 1'b1;
    rd_index[4:0] = 5'd12;
    #1;
    chk("drop_no_fwd", port(0), 8'h87);
    chk("drop_ready_hi", stream_ready, 1'b1);
    step();
    stream_valid = 1'b0;
    clear_req    = 1'b0;
    chk("clr_lut_ready", lut_ready, 1'b0);
    wait_clear("clr");
    chk("clr_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      chk($sformatf("clr_e%0d", i), v, 8'h00);
    end

    // asynchronous reset mid-burst
    wr_valid = 1'b1; wr_index = 5'd20;
    wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    start(5'd21, 6'd3);
    beat(8'hC1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lut_ready", lut_ready, 1'b0);
    chk("arst_stream_ready", stream_ready, 1'b0);
    chk("arst_wr_ready", wr_ready, 1'b0);
    chk("arst_rd_value", rd_value, 16'h0);
    step();
    rst_n = 1'b1;
    wait_clear("arst");
    rd(5'd20, v); chk("arst_e20", v, 8'h00);
    rd(5'd21, v); chk("arst_e21", v, 8'h00);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
